// File: rtl/lcd_pkg.sv
// Shared types, init ROM and command helpers for the HD44780 write controller.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWR_WAIT,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_EXEC_WAIT,
      ST_IDLE
   } lcd_state_e;

   // One byte as it appears on the LCD bus: register select plus data.
   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_byte_t;

   localparam logic [7:0] CMD_CLEAR  = 8'h01;
   localparam logic [7:0] CMD_HOME   = 8'h02;
   localparam logic [7:0] FUNC_SET   = 8'h38;
   localparam logic [7:0] DISP_ON    = 8'h0C;
   localparam logic [7:0] ENTRY_MODE = 8'h06;

   localparam int INIT_LEN = 6;

   // Power-on sequence: 8-bit bus, 2 lines, display on, clear, increment.
   localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
      FUNC_SET, FUNC_SET, FUNC_SET, DISP_ON, CMD_CLEAR, ENTRY_MODE
   };

   // Clear and Home (0x02 and its don't-care twin 0x03) need the long wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == 8'h03));
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter that saturates at zero; one instance times every state.
module lcd_timer #(
   parameter int unsigned    W       = 8,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] value_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Load wins over counting; parked at zero once expired.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register; reset value primes the power-on wait.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= RST_VAL;
      else         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write controller: power-on init sequence, then one byte per handshake
// with setup / enable / hold / execution-wait timing on the LCD pins.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned EN_CYC    = 12,
   parameter int unsigned HOLD_CYC  = 2,
   parameter int unsigned EXEC_CYC  = 2000,
   parameter int unsigned CLR_CYC   = 82000,
   parameter int unsigned PWR_CYC   = 750000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_valid_i,
   input  logic       req_rs_i,
   input  logic [7:0] req_data_i,
   output logic       req_ready_o,
   output logic       init_done_o,
   output logic       lcd_on_o,
   output logic       lcd_en_o,
   output logic       lcd_rs_o,
   output logic       lcd_rw_o,
   output logic [7:0] lcd_data_o
);

   localparam int unsigned MAX_CYC = max2(max2(max2(SETUP_CYC, EN_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                          max2(CLR_CYC, PWR_CYC));
   localparam int unsigned CW = $clog2(MAX_CYC) + 1;

   // Each state lasts N cycles: the counter is loaded with N-1 on entry.
   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
   localparam logic [CW-1:0] CLR_LD   = CW'(CLR_CYC - 1);
   localparam logic [CW-1:0] PWR_LD   = CW'(PWR_CYC - 1);

   localparam logic [2:0] IDX_LAST = 3'(INIT_LEN - 1);

   lcd_state_e    state_q, state_d;
   lcd_byte_t     byte_q, byte_d;
   logic [2:0]    idx_q, idx_d;
   logic          done_q, done_d;
   logic          en_q, ready_q, on_q;

   logic          tmr_load;
   logic [CW-1:0] tmr_value;
   logic          tmr_zero;

   lcd_timer #(
      .W       (CW),
      .RST_VAL (PWR_LD)
   ) u_timer (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (tmr_load),
      .value_i (tmr_value),
      .zero_o  (tmr_zero)
   );

   // Next-state logic: walk the per-byte sequence, feeding it from the ROM
   // until init is done and from the request port afterwards.
   always_comb begin
      state_d   = state_q;
      byte_d    = byte_q;
      idx_d     = idx_q;
      done_d    = done_q;
      tmr_load  = 1'b0;
      tmr_value = '0;
      unique case (state_q)
         ST_PWR_WAIT: begin
            if (tmr_zero) begin
               state_d   = ST_SETUP;
               byte_d    = '{rs: 1'b0, data: INIT_ROM[idx_q]};
               tmr_load  = 1'b1;
               tmr_value = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (tmr_zero) begin
               state_d   = ST_PULSE;
               tmr_load  = 1'b1;
               tmr_value = EN_LD;
            end
         end
         ST_PULSE: begin
            if (tmr_zero) begin
               state_d   = ST_HOLD;
               tmr_load  = 1'b1;
               tmr_value = HOLD_LD;
            end
         end
         ST_HOLD: begin
            if (tmr_zero) begin
               state_d   = ST_EXEC_WAIT;
               tmr_load  = 1'b1;
               tmr_value = is_long_cmd(byte_q.rs, byte_q.data) ? CLR_LD : EXEC_LD;
            end
         end
         ST_EXEC_WAIT: begin
            if (tmr_zero) begin
               if (done_q) begin
                  state_d = ST_IDLE;
               end else if (idx_q == IDX_LAST) begin
                  idx_d   = idx_q + 3'd1;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  idx_d     = idx_q + 3'd1;
                  byte_d    = '{rs: 1'b0, data: INIT_ROM[idx_q + 3'd1]};
                  state_d   = ST_SETUP;
                  tmr_load  = 1'b1;
                  tmr_value = SETUP_LD;
               end
            end
         end
         ST_IDLE: begin
            if (req_valid_i && ready_q) begin
               byte_d    = '{rs: req_rs_i, data: req_data_i};
               state_d   = ST_SETUP;
               tmr_load  = 1'b1;
               tmr_value = SETUP_LD;
            end
         end
         default: begin
            state_d = ST_PWR_WAIT;
         end
      endcase
   end

   // State and pin registers; pin levels are derived from the next state so
   // they change on the same edge as the state they belong to.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_PWR_WAIT;
         byte_q  <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         en_q    <= 1'b0;
         ready_q <= 1'b0;
         on_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         en_q    <= (state_d == ST_PULSE);
         ready_q <= (state_d == ST_IDLE) && done_d;
         on_q    <= 1'b1;
      end
   end

   assign req_ready_o = ready_q;
   assign init_done_o = done_q;
   assign lcd_on_o    = on_q;
   assign lcd_en_o    = en_q;
   assign lcd_rs_o    = byte_q.rs;
   assign lcd_rw_o    = 1'b0;
   assign lcd_data_o  = byte_q.data;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with a byte scoreboard checked on every EN rise.
module tb_lcd_ctrl;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic       req_valid_i;
   logic       req_rs_i;
   logic [7:0] req_data_i;
   logic       req_ready_o;
   logic       init_done_o;
   logic       lcd_on_o;
   logic       lcd_en_o;
   logic       lcd_rs_o;
   logic       lcd_rw_o;
   logic [7:0] lcd_data_o;

   int vecs = 0;
   int errs = 0;
   int npulse = 0;
   logic [8:0] sb [$];

   lcd_ctrl #(
      .SETUP_CYC (2),
      .EN_CYC    (3),
      .HOLD_CYC  (2),
      .EXEC_CYC  (5),
      .CLR_CYC   (9),
      .PWR_CYC   (10)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_rs_i    (req_rs_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .init_done_o (init_done_o),
      .lcd_on_o    (lcd_on_o),
      .lcd_en_o    (lcd_en_o),
      .lcd_rs_o    (lcd_rs_o),
      .lcd_rw_o    (lcd_rw_o),
      .lcd_data_o  (lcd_data_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_rom();
      sb.push_back({1'b0, 8'h38});
      sb.push_back({1'b0, 8'h38});
      sb.push_back({1'b0, 8'h38});
      sb.push_back({1'b0, 8'h0C});
      sb.push_back({1'b0, 8'h01});
      sb.push_back({1'b0, 8'h06});
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_en"},    {31'd0, lcd_en_o},    32'd0);
      chk({tag, "_rs"},    {31'd0, lcd_rs_o},    32'd0);
      chk({tag, "_rw"},    {31'd0, lcd_rw_o},    32'd0);
      chk({tag, "_data"},  {24'd0, lcd_data_o},  32'd0);
      chk({tag, "_ready"}, {31'd0, req_ready_o}, 32'd0);
      chk({tag, "_done"},  {31'd0, init_done_o}, 32'd0);
      chk({tag, "_on"},    {31'd0, lcd_on_o},    32'd0);
   endtask

   // Called #1 after a rising edge; returns at the same phase with ready high.
   task automatic wait_ready(input string tag);
      for (int i = 0; i < 200 && !req_ready_o; i++) begin
         @(posedge clk); #1;
      end
      chk({tag, "_ready_wait"}, {31'd0, req_ready_o}, 32'd1);
   endtask

   // One handshake, then count the cycles ready stays low.
   task automatic do_write(input string tag, input logic rs, input logic [7:0] d, input int busy);
      int cnt;
      wait_ready(tag);
      req_valid_i = 1'b1; req_rs_i = rs; req_data_i = d;
      sb.push_back({rs, d});
      @(posedge clk); #1;
      req_valid_i = 1'b0; req_data_i = 8'hEE;
      cnt = 0;
      while (!req_ready_o && cnt < 200) begin
         cnt++;
         @(posedge clk); #1;
      end
      chk({tag, "_busy"}, cnt, busy);
   endtask

   // Scoreboard monitor: each EN rise must match the oldest expected byte,
   // each completed pulse must be exactly EN_CYC wide.
   logic en_prev = 1'b0;
   int   en_w = 0;
   always @(negedge clk) begin
      logic [8:0] e;
      if (lcd_en_o && !en_prev) begin
         npulse++;
         chk("pulse_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("pin_rs",   {31'd0, lcd_rs_o},   {31'd0, e[8]});
            chk("pin_data", {24'd0, lcd_data_o}, {24'd0, e[7:0]});
         end
         chk("pin_rw", {31'd0, lcd_rw_o}, 32'd0);
         en_w = 1;
      end else if (lcd_en_o) begin
         en_w++;
      end else if (en_prev && rst_ni) begin
         chk("en_width", en_w, 3);
      end
      en_prev = lcd_en_o;
   end

   initial begin
      int cnt;
      int base;
      logic on_first;
      rst_ni = 1'b0; req_valid_i = 1'b0; req_rs_i = 1'b0; req_data_i = 8'h00;
      on_first = 1'b0;

      // Reset values, then release and time the first EN rise.
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      push_rom();
      rst_ni = 1'b1;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         cnt++;
         if (cnt == 1) on_first = lcd_on_o;
         if (lcd_en_o) break;
      end
      chk("first_en_cycles", cnt, 12);
      chk("on_after_release", {31'd0, on_first}, 32'd1);
      chk("ready_during_init", {31'd0, req_ready_o}, 32'd0);

      for (int i = 0; i < 300 && !init_done_o; i++) begin
         @(posedge clk); #1;
      end
      chk("init_done", {31'd0, init_done_o}, 32'd1);
      chk("init_ready", {31'd0, req_ready_o}, 32'd1);
      chk("init_pulses", npulse, 6);
      chk("init_sb_empty", sb.size(), 0);

      // Ordinary data, Clear (long wait), Set DDRAM address (short wait).
      do_write("data41", 1'b1, 8'h41, 12);
      do_write("clear", 1'b0, 8'h01, 16);
      do_write("home3", 1'b0, 8'h03, 16);
      do_write("addr80", 1'b0, 8'h80, 12);

      // Valid held across two bytes; data noise while busy is ignored.
      base = npulse;
      wait_ready("b2b");
      req_valid_i = 1'b1; req_rs_i = 1'b1; req_data_i = 8'h48;
      sb.push_back({1'b1, 8'h48});
      @(posedge clk); #1;
      req_data_i = 8'h5A;
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_hold_data", {24'd0, lcd_data_o}, 32'h48);
      chk("b2b_busy", {31'd0, req_ready_o}, 32'd0);
      req_data_i = 8'h49;
      sb.push_back({1'b1, 8'h49});
      wait_ready("b2b2");
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("b2b_pulses", npulse - base, 2);
      chk("b2b_sb_empty", sb.size(), 0);

      // Reset while EN is high, with a request already pending for after init.
      wait_ready("mid");
      req_valid_i = 1'b1; req_rs_i = 1'b1; req_data_i = 8'h41;
      sb.push_back({1'b1, 8'h41});
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      for (int i = 0; i < 50 && !lcd_en_o; i++) begin
         @(posedge clk); #1;
      end
      chk("mid_en_seen", {31'd0, lcd_en_o}, 32'd1);
      rst_ni = 1'b0;
      req_valid_i = 1'b1; req_rs_i = 1'b1; req_data_i = 8'h55;
      @(posedge clk); #1;
      chk_reset_vals("midrst");
      @(posedge clk); #1;
      push_rom();
      sb.push_back({1'b1, 8'h55});
      base = npulse;
      rst_ni = 1'b1;
      for (int i = 0; i < 300 && !init_done_o; i++) begin
         @(posedge clk); #1;
      end
      chk("rerun_done", {31'd0, init_done_o}, 32'd1);
      chk("rerun_ready", {31'd0, req_ready_o}, 32'd1);
      chk("rerun_last_rom", {24'd0, lcd_data_o}, 32'h06);
      chk("rerun_pulses", npulse - base, 6);
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      chk("pending_taken", {31'd0, req_ready_o}, 32'd0);
      wait_ready("pending");
      chk("pending_pulses", npulse - base, 7);
      chk("final_sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
